// File: rtl/branch_pkg.sv
// Shared types and 2-bit saturating counter helpers for the branch predictor.
package branch_pkg;

  typedef enum logic [1:0] {BR_NONE, BR_BRANCH, BR_JAL, BR_JALR} br_type_e;
  typedef enum logic [1:0] {PC_SEQ, PC_TGT, PC_RCV} pc_sel_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] sat2_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat2_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB + BHT storage: async lookup and training read ports, one sync write port.
module btb_table
  import branch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [XLEN-1:0]  rd_target,
  output logic [1:0]       rd_ctr,
  input  logic [IDX_W-1:0] tr_idx,
  output logic [1:0]       tr_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_install,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [1:0]       wr_ctr
);

  logic [ENTRIES-1:0]      valid;
  logic [ENTRIES-1:0][1:0] ctr;
  logic [TAG_W-1:0]        tag_mem [ENTRIES];
  logic [XLEN-1:0]         tgt_mem [ENTRIES];

  assign rd_valid  = valid[rd_idx];
  assign rd_tag    = tag_mem[rd_idx];
  assign rd_target = tgt_mem[rd_idx];
  assign rd_ctr    = ctr[rd_idx];
  assign tr_ctr    = ctr[tr_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      ctr   <= {ENTRIES{CTR_WNT}};
    end else if (wr_en) begin
      ctr[wr_idx] <= wr_ctr;
      if (wr_install) valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are only observed through valid.
  always_ff @(posedge clk) begin
    if (wr_en && wr_install) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// IF-stage BTB/BHT prediction, EX-stage resolve with flush/pc-select, delayed training, perf counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [1:0]        ex_br_type,
  input  logic              ex_cond,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic [1:0]        pc_sel,
  output logic              flush,
  output logic [PERF_W-1:0] mispred_cnt,
  output logic [PERF_W-1:0] resolved_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef struct packed {
    logic             vld;
    br_type_e         br;
    logic             taken;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } train_t;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [XLEN-1:0]  rd_target;
  logic [1:0]       rd_ctr, tr_ctr, wr_ctr;
  logic             hit, actual, is_cf, mispred;
  br_type_e         br_type;
  train_t           tr;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};
  assign br_type        = br_type_e'(ex_br_type);

  btb_table #(.XLEN(XLEN), .ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (if_pc[IDX_W+1:2]),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_target  (rd_target),
    .rd_ctr     (rd_ctr),
    .tr_idx     (tr.idx),
    .tr_ctr     (tr_ctr),
    .wr_en      (tr.vld),
    .wr_idx     (tr.idx),
    .wr_install (tr.taken),
    .wr_tag     (tr.tag),
    .wr_target  (tr.target),
    .wr_ctr     (wr_ctr)
  );

  assign hit         = rd_valid && (rd_tag == if_pc[XLEN-1:IDX_W+2]) && rd_ctr[1];
  assign pred_taken  = hit;
  assign pred_target = hit ? rd_target : '0;

  assign actual  = (br_type == BR_BRANCH && ex_cond) || br_type == BR_JAL || br_type == BR_JALR;
  assign is_cf   = ex_valid && br_type != BR_NONE;
  assign mispred = is_cf && ((actual != ex_pred_taken) ||
                             (actual && ex_pred_taken && ex_pred_target != ex_target));
  assign flush   = mispred;

  always_comb begin
    pc_sel = PC_SEQ;
    if (mispred) pc_sel = actual ? PC_TGT : PC_RCV;
  end

  // Counter is read from the table in the write cycle, so a back-to-back
  // update to the same index already sees the previous write.
  always_comb begin
    wr_ctr = tr.taken ? sat2_inc(tr_ctr) : sat2_dec(tr_ctr);
    if (tr.br == BR_JAL) wr_ctr = CTR_ST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr <= '0;
    end else begin
      tr.vld    <= is_cf && br_type != BR_JALR;
      tr.br     <= br_type;
      tr.taken  <= actual;
      tr.idx    <= ex_pc[IDX_W+1:2];
      tr.tag    <= ex_pc[XLEN-1:IDX_W+2];
      tr.target <= ex_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt  <= '0;
      resolved_cnt <= '0;
    end else begin
      if (is_cf && resolved_cnt != {PERF_W{1'b1}}) resolved_cnt <= resolved_cnt + 1'b1;
      if (mispred && mispred_cnt != {PERF_W{1'b1}}) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; narrow perf counters so saturation is reachable.
module tb_branch_predict_unit;
  import branch_pkg::*;

  localparam int XLEN = 32, ENTRIES = 16, PERF_W = 4;

  logic              clk, rst_n;
  logic [XLEN-1:0]   if_pc, pred_target, ex_pc, ex_target, ex_pred_target;
  logic              pred_taken, ex_valid, ex_cond, ex_pred_taken, flush;
  logic [1:0]        ex_br_type, pc_sel;
  logic [PERF_W-1:0] mispred_cnt, resolved_cnt;

  int checks = 0;
  int errors = 0;

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .PERF_W(PERF_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_br_type     (ex_br_type),
    .ex_cond        (ex_cond),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc_sel         (pc_sel),
    .flush          (flush),
    .mispred_cnt    (mispred_cnt),
    .resolved_cnt   (resolved_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ex(input logic [31:0] pc, input logic [1:0] t, input logic c,
                    input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_pc = pc; ex_br_type = t; ex_cond = c;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic bubble;
    ex_valid = 1'b0; ex_pc = '0; ex_br_type = BR_NONE; ex_cond = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic chk_res(input string tag, input logic f, input logic [1:0] sel);
    chk({tag, "_flush"}, 32'(flush), 32'(f));
    chk({tag, "_sel"}, 32'(pc_sel), 32'(sel));
  endtask

  task automatic chk_cnt(input string tag, input int res, input int mis);
    chk({tag, "_resolved"}, 32'(resolved_cnt), res);
    chk({tag, "_mispred"}, 32'(mispred_cnt), mis);
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    if_pc = 32'h100;
    #2;
    chk("rst_pred", 32'(pred_taken), 0);
    chk("rst_ptgt", pred_target, 0);
    chk_res("rst", 1'b0, PC_SEQ);
    chk_cnt("rst", 0, 0);
    #10 rst_n = 1'b1;
    tick();

    // Taken branch, cold table
    ex(32'h100, BR_BRANCH, 1'b1, 32'h80, 1'b0, 32'h0);
    chk_res("br_taken", 1'b1, PC_TGT);
    tick(); bubble(); look(32'h100);
    chk("no_bypass", 32'(pred_taken), 0);
    tick(); look(32'h100);
    chk("br_learn_pred", 32'(pred_taken), 1);
    chk("br_learn_tgt", pred_target, 32'h80);

    // Not-taken twice: 10 -> 01 -> 00
    ex(32'h100, BR_BRANCH, 1'b0, 32'h80, 1'b1, 32'h80);
    chk_res("nt1", 1'b1, PC_RCV);
    tick(); bubble(); tick(); look(32'h100);
    chk("nt1_pred", 32'(pred_taken), 0);
    ex(32'h100, BR_BRANCH, 1'b0, 32'h80, 1'b0, 32'h0);
    chk_res("nt2", 1'b0, PC_SEQ);
    tick(); bubble(); tick();
    chk_cnt("t3", 3, 2);

    // JAL / JALR
    ex(32'h40, BR_JAL, 1'b0, 32'h200, 1'b0, 32'h0);
    chk_res("jal_cold", 1'b1, PC_TGT);
    tick(); bubble(); tick(); look(32'h40);
    chk("jal_pred", 32'(pred_taken), 1);
    chk("jal_ptgt", pred_target, 32'h200);
    look(32'h100);
    chk("jal_evict", 32'(pred_taken), 0);
    ex(32'h40, BR_JAL, 1'b0, 32'h200, 1'b1, 32'h200);
    chk_res("jal_hit", 1'b0, PC_SEQ);
    tick();
    ex(32'h40, BR_JAL, 1'b0, 32'h200, 1'b1, 32'h204);
    chk_res("jal_badtgt", 1'b1, PC_TGT);
    tick();
    ex(32'h84, BR_JALR, 1'b0, 32'h300, 1'b0, 32'h0);
    chk_res("jalr_cold", 1'b1, PC_TGT);
    tick();
    ex(32'h84, BR_JALR, 1'b0, 32'h300, 1'b1, 32'h300);
    chk_res("jalr_match", 1'b0, PC_SEQ);
    tick(); bubble(); tick(); look(32'h84);
    chk("jalr_noinst", 32'(pred_taken), 0);
    chk_cnt("t4", 8, 5);

    // Aliasing and back-to-back same-index training
    ex(32'h140, BR_BRANCH, 1'b1, 32'h500, 1'b0, 32'h0);
    chk_res("alias_inst", 1'b1, PC_TGT);
    tick(); bubble(); tick(); look(32'h100);
    chk("alias_miss", 32'(pred_taken), 0);
    look(32'h140);
    chk("alias_hit", 32'(pred_taken), 1);
    chk("alias_tgt", pred_target, 32'h500);
    ex(32'h8, BR_BRANCH, 1'b1, 32'h600, 1'b0, 32'h0);
    tick();
    ex(32'h8, BR_BRANCH, 1'b1, 32'h600, 1'b0, 32'h0);
    tick();
    ex(32'h8, BR_BRANCH, 1'b0, 32'h600, 1'b1, 32'h600);
    chk_res("b2b_nt", 1'b1, PC_RCV);
    tick(); bubble(); tick(); look(32'h8);
    chk("b2b_pred", 32'(pred_taken), 1);
    chk("b2b_tgt", pred_target, 32'h600);
    chk_cnt("t5", 12, 9);

    // Saturation of perf counters
    for (int i = 0; i < 8; i++) begin
      ex(32'h84, BR_JALR, 1'b0, 32'h300, 1'b0, 32'h0);
      tick();
    end
    bubble(); #1;
    chk_cnt("sat", 15, 15);

    // Reset with a training write pending
    ex(32'hC, BR_BRANCH, 1'b1, 32'h700, 1'b0, 32'h0);
    tick(); bubble(); look(32'h140);
    chk("pre_rst_pred", 32'(pred_taken), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pred", 32'(pred_taken), 0);
    chk_res("mid_rst", 1'b0, PC_SEQ);
    chk_cnt("mid_rst", 0, 0);
    #3 rst_n = 1'b1;
    tick(); tick(); look(32'hC);
    chk("drop_pending", 32'(pred_taken), 0);
    look(32'h8);
    chk("post_rst_8", 32'(pred_taken), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
